// File: rtl/counter_arbiter.sv
// Round-robin share of one up-counter timer across NUM_REQ requesters; grant 1 cycle after request, done D cycles later.
// enable_i low stalls the count; requests are sampled only in IDLE. COUNTER_ARBITER_ABORT_EN: dropping req mid-count aborts.
module counter_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int MAX_COUNTER_VALUE = 160,
  localparam int CNT_W            = $clog2(MAX_COUNTER_VALUE + 1),
  localparam int ID_W             = $clog2(NUM_REQ)
) (
  input  logic                     clock_i,
  input  logic                     reset_n_i,
  input  logic                     enable_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*CNT_W-1:0] duration_i,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     busy_o,
  output logic [ID_W-1:0]          active_id_o,
  output logic [CNT_W-1:0]         counter_val_o
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    active_id_q, active_id_d, win_id;
  logic [CNT_W-1:0]   cnt_q, cnt_d, dur_q, dur_d, dur_raw, dur_win;
  logic               win_vld;
  logic               abort;

  // Descending scan so the requester closest after the last grantee is written last and wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req_i[(int'(active_id_q) + i) % NUM_REQ]) begin
        win_vld = 1'b1;
        win_id  = ID_W'((int'(active_id_q) + i) % NUM_REQ);
      end
    end
  end

  assign dur_raw = duration_i[int'(win_id)*CNT_W +: CNT_W];

  always_comb begin
    dur_win = dur_raw;
    if (dur_raw > CNT_W'(MAX_COUNTER_VALUE)) begin
      dur_win = CNT_W'(MAX_COUNTER_VALUE);
    end else if (dur_raw == '0) begin
      dur_win = CNT_W'(1);
    end
  end

`ifdef COUNTER_ARBITER_ABORT_EN
  assign abort = ~req_i[active_id_q];
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    active_id_d = active_id_q;
    cnt_d       = cnt_q;
    dur_d       = dur_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d     = COUNT;
          grant_d     = NUM_REQ'(1) << win_id;
          active_id_d = win_id;
          cnt_d       = '0;
          dur_d       = dur_win;
        end
      end
      COUNT: begin
        if (abort) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (enable_i) begin
          if (cnt_q == dur_q - CNT_W'(1)) begin
            cnt_d   = dur_q;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      active_id_q <= ID_W'(NUM_REQ - 1);
      cnt_q       <= '0;
      dur_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      active_id_q <= active_id_d;
      cnt_q       <= cnt_d;
      dur_q       <= dur_d;
    end
  end

  assign grant_o       = grant_q;
  assign done_o        = (state_q == DONE) ? grant_q : '0;
  assign busy_o        = (state_q != IDLE);
  assign active_id_o   = active_id_q;
  assign counter_val_o = cnt_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Randomized bench for counter_arbiter against a transaction-level model of grants and elapsed enabled cycles.
module tb_counter_arbiter;
  localparam int NUM_REQ = 4;
  localparam int MAXV    = 160;
  localparam int CNT_W   = $clog2(MAXV + 1);
  localparam int ID_W    = $clog2(NUM_REQ);

  logic                     clock_i = 1'b0;
  logic                     reset_n_i;
  logic                     enable_i;
  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*CNT_W-1:0] duration_i;
  logic [NUM_REQ-1:0]       grant_o;
  logic [NUM_REQ-1:0]       done_o;
  logic                     busy_o;
  logic [ID_W-1:0]          active_id_o;
  logic [CNT_W-1:0]         counter_val_o;

  int n_checks = 0;
  int n_errors = 0;

  // Model: a grant is an (owner, length) record plus elapsed enabled cycles.
  bit m_granted;
  bit m_finished;
  int m_owner;
  int m_len;
  int m_elapsed;
  int m_last;

  counter_arbiter #(.NUM_REQ(NUM_REQ), .MAX_COUNTER_VALUE(MAXV)) dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .enable_i(enable_i),
    .req_i(req_i), .duration_i(duration_i), .grant_o(grant_o),
    .done_o(done_o), .busy_o(busy_o), .active_id_o(active_id_o),
    .counter_val_o(counter_val_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int effective_len(input int d);
    if (d > MAXV) return MAXV;
    if (d == 0) return 1;
    return d;
  endfunction

  task automatic model_reset();
    m_granted  = 0;
    m_finished = 0;
    m_owner    = 0;
    m_len      = 0;
    m_elapsed  = 0;
    m_last     = NUM_REQ - 1;
  endtask

  task automatic model_step();
    bit dropped;
    dropped = 0;
    if (m_finished) begin
      m_finished = 0;
      m_granted  = 0;
      m_elapsed  = 0;
    end else if (m_granted) begin
`ifdef COUNTER_ARBITER_ABORT_EN
      dropped = !req_i[m_owner];
`endif
      if (dropped) begin
        m_granted = 0;
        m_elapsed = 0;
      end else if (enable_i) begin
        m_elapsed++;
        if (m_elapsed == m_len) m_finished = 1;
      end
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int idx;
        idx = (m_last + k) % NUM_REQ;
        if (!m_granted && req_i[idx]) begin
          m_granted = 1;
          m_owner   = idx;
          m_last    = idx;
          m_len     = effective_len(int'(duration_i[idx*CNT_W +: CNT_W]));
          m_elapsed = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("grant", grant_o, m_granted ? (1 << m_owner) : 0);
    check("done", done_o, m_finished ? (1 << m_owner) : 0);
    check("busy", busy_o, m_granted);
    check("active_id", active_id_o, m_last);
    check("counter", counter_val_o, m_elapsed);
  endtask

  function automatic int rand_dur();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 0;
    if (r == 1) return $urandom_range(150, 255);
    return $urandom_range(1, 12);
  endfunction

  task automatic drive_inputs();
    enable_i = ($urandom_range(0, 9) < 8);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_i[i] && m_finished && m_owner == i) begin
        req_i[i] = 1'b0;
      end else if (!req_i[i] && $urandom_range(0, 3) == 0) begin
        req_i[i] = 1'b1;
        duration_i[i*CNT_W +: CNT_W] = CNT_W'(rand_dur());
      end else if (req_i[i] && $urandom_range(0, 63) == 0) begin
        req_i[i] = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) duration_i[i*CNT_W +: CNT_W] = CNT_W'(rand_dur());
    end
  endtask

  initial begin
    int waited;
    reset_n_i  = 1'b0;
    enable_i   = 1'b1;
    req_i      = '1;
    duration_i = '0;
    for (int i = 0; i < NUM_REQ; i++) duration_i[i*CNT_W +: CNT_W] = CNT_W'(3);
    model_reset();

    repeat (2) begin
      @(negedge clock_i);
      check("rst_grant", grant_o, 0);
      check("rst_counter", counter_val_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_active", active_id_o, NUM_REQ - 1);
    end
    reset_n_i = 1'b1;

    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(posedge clock_i);
      model_step();
      @(negedge clock_i);
      check_outputs();
      if (cyc == 0) check("first_grant", grant_o, 1);
      drive_inputs();
    end

    // Steer into a live count, then pull reset asynchronously.
    req_i    = 4'b0100;
    enable_i = 1'b1;
    duration_i[2*CNT_W +: CNT_W] = CNT_W'(20);
    waited = 0;
    while (!(m_granted && !m_finished && m_elapsed >= 2) && waited < 400) begin
      @(posedge clock_i);
      model_step();
      @(negedge clock_i);
      check_outputs();
      if (m_finished) req_i = '0;
      else req_i = 4'b0100;
      waited++;
    end
    if (waited >= 400) check("midrst_wait", 0, 1);
    reset_n_i = 1'b0;
    #1;
    check("midrst_grant", grant_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_counter", counter_val_o, 0);
    check("midrst_active", active_id_o, NUM_REQ - 1);
    repeat (2) begin
      @(negedge clock_i);
      check("midrst_done", done_o, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
